// File: rtl/instruction_fetch_unit_pkg.sv
// instruction_fetch_unit_pkg: shared widths, instruction constants and fetch FSM state encoding
package instruction_fetch_unit_pkg;

    localparam int XLEN_DEF = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [4:0] OP_R      = 5'b01100;
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BRANCH = 5'b11000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } fetch_state_t;

    function automatic logic [4:0] opcode_of(input logic [31:0] i);
        return i[6:2];
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_queue.sv
// instruction_fetch_unit_queue: small FIFO of {inst, pc} entries with flush and combinational head
module instruction_fetch_unit_queue #(
    parameter int W     = 64,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               din,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [W-1:0]               dout
);

    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_push, do_pop;

    assign do_pop  = pop && count != '0;
    assign do_push = push && (count != FULL || do_pop);
    assign dout    = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wp <= wp == LAST ? '0 : wp + 1'b1;
            if (do_pop)
                rp <= rp == LAST ? '0 : rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wp] <= din;
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register and single-outstanding fetch FSM feeding the decoder
// through a 2-entry queue; branch redirects flush the queue and restart fetch.
module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int              XLEN      = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            misalign_err
);

    localparam int CW = $clog2(BUF_DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(BUF_DEPTH);

    fetch_state_t      state;
    logic [XLEN-1:0]   pc, req_pc;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] head;
    logic              push, pop, credit, room_after;

    assign inst_valid = count != '0;
    assign pop        = inst_valid && inst_ready;
    assign push       = state == S_WAIT && imem_rvalid && !redirect_valid;
    assign credit     = count < FULL;
    assign room_after = pop || count < FULL - 1'b1;
    assign imem_req   = state == S_REQ;
    assign imem_addr  = pc;
    assign inst       = inst_valid ? head[2*XLEN-1:XLEN] : XLEN'(NOP);
    assign inst_pc    = inst_valid ? head[XLEN-1:0] : '0;

    instruction_fetch_unit_queue #(
        .W     (2 * XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({imem_rdata, req_pc}),
        .pop   (pop),
        .flush (redirect_valid),
        .count (count),
        .dout  (head)
    );

    // A response still owed by memory after a redirect is drained rather than queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            req_pc       <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_valid && redirect_pc[1:0] != 2'b00;
            if (redirect_valid) begin
                pc    <= {redirect_pc[XLEN-1:2], 2'b00};
                state <= (state == S_WAIT || state == S_DRAIN) ? (imem_rvalid ? S_REQ : S_DRAIN) :
                         (state == S_REQ && imem_gnt) ? S_DRAIN : S_REQ;
            end else begin
                case (state)
                    S_IDLE:  if (credit) state <= S_REQ;
                    S_REQ:   if (imem_gnt) begin
                                 pc     <= pc + XLEN'(4);
                                 req_pc <= pc;
                                 state  <= S_WAIT;
                             end
                    S_WAIT:  if (imem_rvalid) state <= room_after ? S_REQ : S_IDLE;
                    S_DRAIN: if (imem_rvalid) state <= S_REQ;
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed stimulus with a scoreboard queue checked by an output monitor
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1, rst2_n = 1'b1;
    logic        imem_req, imem_gnt, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_valid, inst_ready = 1'b0, misalign_err;
    logic [31:0] inst, inst_pc;

    logic        w_req, w_rvalid, w_valid, w_mis;
    logic [31:0] w_addr, w_inst, w_pc;

    int          passed = 0, total = 0;
    int          allowed = 0, granted;
    logic        rv_hold = 1'b0, pend, wpend;
    logic [31:0] paddr;
    logic [63:0] sb[$];
    logic [31:0] waddrs[$];

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
        .inst_pc(inst_pc), .misalign_err(misalign_err)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst2_n),
        .imem_req(w_req), .imem_addr(w_addr), .imem_gnt(w_req),
        .imem_rvalid(w_rvalid), .imem_rdata(32'h0000_0013),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .inst_valid(w_valid), .inst_ready(1'b1), .inst(w_inst),
        .inst_pc(w_pc), .misalign_err(w_mis)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h00A0_0093;
            32'h4:   return 32'h0020_8133;
            32'h8:   return 32'h0000_A183;
            default: return {a[23:0], 8'h13};
        endcase
    endfunction

    assign imem_gnt    = imem_req && granted < allowed;
    assign imem_rvalid = pend && !rv_hold;
    assign imem_rdata  = mem_word(paddr);
    assign w_rvalid    = wpend;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= 1'b0;
            granted <= 0;
            paddr   <= '0;
        end else begin
            if (imem_rvalid) pend <= 1'b0;
            if (imem_gnt) begin
                pend    <= 1'b1;
                paddr   <= imem_addr;
                granted <= granted + 1;
            end
        end
    end

    always @(posedge clk or negedge rst2_n) begin
        if (!rst2_n) begin
            wpend <= 1'b0;
        end else begin
            wpend <= w_req;
            if (w_req) waddrs.push_back(w_addr);
        end
    end

    task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_inst: got pc %h inst %h expected none", inst_pc, inst);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check("inst", inst, e[63:32]);
                check("inst_pc", inst_pc, e[31:0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_inst(input logic [31:0] pc, input logic [31:0] w);
        sb.push_back({w, pc});
    endtask

    task automatic wait_sb_empty(input string n, input int lim);
        int k = 0;
        while (sb.size() != 0 && k < lim) begin
            step();
            k++;
        end
        check({n, "_drained"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic wait_granted(input int g, input int lim);
        int k = 0;
        while (granted < g && k < lim) begin
            step();
            k++;
        end
        check("granted", granted, g);
    endtask

    initial begin
        int k;
        #1 rst_n = 1'b0;
        rst2_n = 1'b0;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_valid", inst_valid, 0);
        check("rst_inst", inst, 32'h13);
        check("wrap_rst_addr", w_addr, 32'hFFFF_FFFC);
        step();
        rst_n = 1'b1;
        step();
        check("cycle1_req", imem_req, 1);
        check("cycle1_addr", imem_addr, 0);

        // reset asserted while a word is queued and a second fetch is in flight
        allowed = 1;
        k = 0;
        while (!inst_valid && k < 20) begin
            step();
            k++;
        end
        rv_hold = 1'b1;
        allowed = 2;
        wait_granted(2, 20);
        check("pre_rst_valid", inst_valid, 1);
        check("pre_rst_pc", inst_pc, 0);
        check("pre_rst_inst", inst, 32'h00A0_0093);
        #2 rst_n = 1'b0;
        #1;
        check("async_req", imem_req, 0);
        check("async_addr", imem_addr, 0);
        check("async_valid", inst_valid, 0);
        check("async_inst", inst, 32'h13);
        check("async_pc", inst_pc, 0);
        check("async_mis", misalign_err, 0);
        allowed = 0;
        rv_hold = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("rel_req", imem_req, 1);
        check("rel_addr", imem_addr, 0);

        // streaming with a 1-cycle memory
        inst_ready = 1'b1;
        expect_inst(32'h0, 32'h00A0_0093);
        expect_inst(32'h4, 32'h0020_8133);
        expect_inst(32'h8, 32'h0000_A183);
        allowed = 3;
        wait_sb_empty("stream", 40);
        step();
        check("stream_next_addr", imem_addr, 32'hC);

        // backpressure: only two words may be fetched
        inst_ready = 1'b0;
        allowed = 7;
        repeat (10) step();
        check("bp_granted", granted, 5);
        check("bp_req", imem_req, 0);
        check("bp_valid", inst_valid, 1);
        check("bp_pc", inst_pc, 32'hC);
        check("bp_inst", inst, 32'h0000_0C13);
        expect_inst(32'hC,  32'h0000_0C13);
        expect_inst(32'h10, 32'h0000_1013);
        expect_inst(32'h14, 32'h0000_1413);
        expect_inst(32'h18, 32'h0000_1813);
        inst_ready = 1'b1;
        wait_sb_empty("bp", 60);
        step();
        check("bp_next_addr", imem_addr, 32'h1C);

        // redirect while a fetch is in flight: its response must be dropped
        rv_hold = 1'b1;
        allowed = 8;
        wait_granted(8, 20);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        step();
        redirect_valid = 1'b0;
        check("rd_valid", inst_valid, 0);
        check("rd_mis", misalign_err, 0);
        repeat (3) step();
        check("rd_drain_req", imem_req, 0);
        expect_inst(32'h100, 32'h0001_0013);
        allowed = 9;
        rv_hold = 1'b0;
        k = 0;
        while (!imem_req && k < 10) begin
            step();
            k++;
        end
        check("rd_req", imem_req, 1);
        check("rd_addr", imem_addr, 32'h100);
        wait_sb_empty("rd", 20);

        // misaligned redirect while a request waits for grant
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        step();
        redirect_valid = 1'b0;
        check("mis_pulse", misalign_err, 1);
        check("mis_addr", imem_addr, 32'h100);
        check("mis_req", imem_req, 1);
        step();
        check("mis_clear", misalign_err, 0);
        expect_inst(32'h100, 32'h0001_0013);
        allowed = 10;
        wait_sb_empty("mis", 20);

        // PC wrap from the top of the address space
        rst2_n = 1'b1;
        k = 0;
        while (waddrs.size() < 2 && k < 20) begin
            step();
            k++;
        end
        check("wrap_reqs", waddrs.size() >= 2, 1);
        if (waddrs.size() >= 2) begin
            check("wrap_first", waddrs[0], 32'hFFFF_FFFC);
            check("wrap_second", waddrs[1], 32'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
